// File: rtl/fifo_byte_packer_pkg.sv
// Shared definitions for the FIFO byte packer: state encodings and the lane-keep mask helper.
package fifo_byte_packer_pkg;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_OUT  = 1'b1;

    // Upper bound on lanes per output word; the mask is built at this width and sliced by users.
    localparam int unsigned MAX_RATIO = 16;

    function automatic logic [MAX_RATIO-1:0] keep_mask(input int unsigned cnt);
        logic [MAX_RATIO-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_RATIO; i++) begin
            m[i] = (i < cnt);
        end
        return m;
    endfunction

endpackage

// File: rtl/pack_idle_timer.sv
// Counts starved cycles while a partial word is held; expired requests an automatic flush.
module pack_idle_timer #(
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] idle_q, idle_d;

    // Saturates at LIMIT so expired stays asserted until the packer leaves FILL.
    always_comb begin
        idle_d = idle_q;
        if (clear) begin
            idle_d = '0;
        end else if (run && idle_q != LIMIT) begin
            idle_d = idle_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign expired = (TIMEOUT != 0) && (idle_q == LIMIT);

endmodule

// File: rtl/fifo_byte_packer.sv
// Pops DATA_WIDTH-bit FIFO entries and packs PACK_RATIO of them into one valid/ready output word,
// emitting a keep-masked partial word on flush or after a starvation timeout.
module fifo_byte_packer
    import fifo_byte_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fifo_empty,
    input  logic [DATA_WIDTH-1:0]            fifo_data,
    output logic                             fifo_rd_en,
    input  logic                             flush,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
    output logic [PACK_RATIO-1:0]            m_keep,
    output logic                             busy
);

    localparam int                   WORD_W  = DATA_WIDTH * PACK_RATIO;
    localparam logic [CNT_WIDTH-1:0] RATIO_C = CNT_WIDTH'(PACK_RATIO);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    logic [0:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 pending_q, pending_d;
    logic                 flush_req_q, flush_req_d;
    logic [WORD_W-1:0]    lanes_q, lanes_d;
    logic [PACK_RATIO-1:0] keep_q, keep_d;
    logic [MAX_RATIO-1:0] keep_full;
    logic                 in_fill, rd_en;
    logic                 idle_run, idle_clear, idle_expired;

    assign in_fill = (state_q == ST_FILL);

    // A flush pulse blocks new reads in its own cycle so only already-issued bytes join the word.
    assign rd_en = in_fill && !fifo_empty && !flush_req_q && !flush
                   && ((count_q + CNT_WIDTH'(pending_q)) < RATIO_C);

    assign keep_full = keep_mask(32'(count_d));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pending_d   = pending_q;
        flush_req_d = flush_req_q;
        lanes_d     = lanes_q;
        keep_d      = keep_q;
        if (in_fill) begin
            pending_d = rd_en;
            if (pending_q) begin
                lanes_d[count_q*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
                count_d = count_q + ONE;
            end
            if (count_d == RATIO_C || (flush_req_q && count_q != '0 && !pending_q)) begin
                state_d     = ST_OUT;
                keep_d      = keep_full[PACK_RATIO-1:0];
                flush_req_d = 1'b0;
            end else if (count_q == '0 && !pending_q) begin
                // Nothing held or in flight: a flush here would only make an empty word.
                flush_req_d = 1'b0;
            end else begin
                flush_req_d = flush_req_q || flush || idle_expired;
            end
        end else begin
            flush_req_d = flush_req_q || flush;
            if (m_ready) begin
                state_d = ST_FILL;
                count_d = '0;
                lanes_d = '0;
                keep_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            count_q     <= '0;
            pending_q   <= 1'b0;
            flush_req_q <= 1'b0;
            lanes_q     <= '0;
            keep_q      <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            flush_req_q <= flush_req_d;
            lanes_q     <= lanes_d;
            keep_q      <= keep_d;
        end
    end

    assign idle_run   = in_fill && count_q != '0 && !pending_q && fifo_empty;
    assign idle_clear = rd_en || (state_d != state_q);

    pack_idle_timer #(
        .TIMEOUT   (TIMEOUT),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (idle_run),
        .clear   (idle_clear),
        .expired (idle_expired)
    );

    assign fifo_rd_en = rd_en;
    assign m_valid    = (state_q == ST_OUT);
    assign m_data     = lanes_q;
    assign m_keep     = keep_q;
    assign busy       = (count_q != '0) || pending_q || m_valid;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer: a behavioural FIFO feeds the packer, output words are
// collected by a handshake monitor and compared against hand-computed values.
module tb_fifo_byte_packer;

    localparam int DW = 8;
    localparam int PR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_data;
    logic [3:0]    m_keep;
    logic          busy;

    always #5 clk = ~clk;

    fifo_byte_packer #(
        .DATA_WIDTH (DW),
        .PACK_RATIO (PR),
        .TIMEOUT    (16),
        .CNT_WIDTH  (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .busy       (busy)
    );

    // Behavioural FIFO: wp advanced by the stimulus, rp by the read strobe.
    logic [7:0] mem [0:1023];
    int         wp = 0;
    int         rp = 0;
    logic       starve = 1'b0;

    assign fifo_empty = (wp == rp) || starve;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= mem[rp[9:0]];
            rp <= rp + 1;
        end
    end

    // Output monitor, sampled on the falling edge ahead of the accepting rising edge.
    logic [31:0] got_d [0:255];
    logic [3:0]  got_k [0:255];
    int          gw = 0;
    int          rd_cnt = 0;
    int          guard_viol = 0;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            got_d[gw[7:0]] = m_data;
            got_k[gw[7:0]] = m_keep;
            gw = gw + 1;
        end
        if (fifo_rd_en) rd_cnt = rd_cnt + 1;
        if (fifo_rd_en && fifo_empty) guard_viol = guard_viol + 1;
    end

    int vectors = 0;
    int miscompares = 0;
    int gr = 0;

    typedef struct {
        logic [31:0] bytes;
        int          n;
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp[9:0]] = b;
        wp++;
    endtask

    task automatic wait_word(input string name, input int budget,
                             output logic [31:0] d, output logic [3:0] k);
        int n = 0;
        while (gr == gw && n < budget) begin
            tick(1);
            n++;
        end
        if (gr == gw) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no output word within %0d cycles", name, budget);
            d = 'x;
            k = 'x;
        end else begin
            d = got_d[gr[7:0]];
            k = got_k[gr[7:0]];
            gr++;
        end
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n = 0;
        while ((rp != wp || busy) && n < budget) begin
            tick(1);
            n++;
        end
        if (rp != wp || busy) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: packer still busy after %0d cycles", name, budget);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  k;
        logic [31:0] w;
        logic [7:0]  eb;
        int          base, bad, nb, n;

        tbl[0] = '{32'h04030201, 4, 32'h04030201, 4'hF};
        tbl[1] = '{32'hDEADBEEF, 4, 32'hDEADBEEF, 4'hF};
        tbl[2] = '{32'h00C0FFEE, 3, 32'h00C0FFEE, 4'h7};
        tbl[3] = '{32'h0000005A, 1, 32'h0000005A, 4'h1};
        tbl[4] = '{32'h0000BEEF, 2, 32'h0000BEEF, 4'h3};
        tbl[5] = '{32'h87654321, 4, 32'h87654321, 4'hF};

        rst = 1'b1;
        m_ready = 1'b1;
        flush = 1'b0;
        tick(3);
        @(negedge clk);
        check("reset_m_valid", {31'b0, m_valid}, 32'h0);
        check("reset_m_data", m_data, 32'h0);
        check("reset_m_keep", {28'b0, m_keep}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_rd_en", {31'b0, fifo_rd_en}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);

        // Basic pack of 01..08 into two full words.
        base = rd_cnt;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_word("basic_w0", 30, d, k);
        check("basic_w0_data", d, 32'h04030201);
        check("basic_w0_keep", {28'b0, k}, 32'hF);
        wait_word("basic_w1", 30, d, k);
        check("basic_w1_data", d, 32'h08070605);
        check("basic_w1_keep", {28'b0, k}, 32'hF);
        tick(3);
        check("basic_rd_count", rd_cnt - base, 32'd8);
        wait_drained("basic_drain", 40);

        // Table of full and timed-out partial words.
        for (int i = 0; i < 6; i++) begin
            w = tbl[i].bytes;
            for (int j = 0; j < tbl[i].n; j++) push(w[8*j +: 8]);
            wait_word($sformatf("tbl%0d", i), 60, d, k);
            check($sformatf("tbl%0d_data", i), d, tbl[i].exp_data);
            check($sformatf("tbl%0d_keep", i), {28'b0, k}, {28'b0, tbl[i].exp_keep});
            wait_drained($sformatf("tbl%0d_drain", i), 60);
        end

        // Backpressure: word held stable, no reads while waiting.
        m_ready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        n = 0;
        while (!m_valid && n < 20) begin
            tick(1);
            n++;
        end
        check("bp_valid_rise", {31'b0, m_valid}, 32'h1);
        push(8'h55);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!m_valid || m_data !== 32'h44332211 || m_keep !== 4'hF || fifo_rd_en) bad++;
        end
        check("bp_hold_bad_cycles", bad, 0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_word("bp_word", 10, d, k);
        check("bp_word_data", d, 32'h44332211);
        @(negedge clk);
        check("bp_valid_after", {31'b0, m_valid}, 32'h0);
        wait_word("bp_tail", 40, d, k);
        check("bp_tail_data", d, 32'h00000055);
        check("bp_tail_keep", {28'b0, k}, 32'h1);
        wait_drained("bp_drain", 40);

        // Timeout: word must not appear during the first 16 starved cycles.
        push(8'hAA); push(8'hBB); push(8'hCC);
        n = 0;
        while (rp != wp && n < 20) begin
            tick(1);
            n++;
        end
        bad = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (m_valid) bad++;
        end
        check("tmo_early_valid", bad, 0);
        wait_word("tmo_word", 6, d, k);
        check("tmo_data", d, 32'h00CCBBAA);
        check("tmo_keep", {28'b0, k}, 32'h7);
        wait_drained("tmo_drain", 40);

        // Explicit flush with two lanes held and the third read in flight.
        push(8'h31); push(8'h32);
        n = 0;
        while (rp != wp && n < 20) begin
            tick(1);
            n++;
        end
        tick(2);
        push(8'h33); push(8'h34);
        tick(1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        wait_word("flush_word", 10, d, k);
        check("flush_data", d, 32'h00333231);
        check("flush_keep", {28'b0, k}, 32'h7);
        wait_word("flush_tail", 40, d, k);
        check("flush_tail_data", d, 32'h00000034);
        wait_drained("flush_drain", 40);

        // Flush with nothing held is dropped.
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_valid || busy) bad++;
        end
        check("flush_empty_bad_cycles", bad, 0);

        // Empty guard with randomly starved FIFO; byte order must survive.
        for (int i = 0; i < 40; i++) push(8'(8'h80 + i));
        base = guard_viol;
        for (int i = 0; i < 200; i++) begin
            starve = 1'($urandom_range(0, 1));
            tick(1);
        end
        starve = 1'b0;
        wait_drained("guard_drain", 300);
        check("guard_rd_while_empty", guard_viol - base, 0);
        nb = 0;
        bad = 0;
        while (gr != gw) begin
            d = got_d[gr[7:0]];
            k = got_k[gr[7:0]];
            gr++;
            for (int l = 0; l < 4; l++) begin
                if (k[l]) begin
                    eb = 8'h80 + 8'(nb);
                    if (d[8*l +: 8] !== eb) bad++;
                    nb++;
                end
            end
        end
        check("guard_order_errors", bad, 0);
        check("guard_byte_count", nb, 40);
        check("guard_total_rd_viol", guard_viol, 0);

        // Reset mid-word discards the partial word.
        push(8'h01); push(8'h02);
        n = 0;
        while (rp != wp && n < 20) begin
            tick(1);
            n++;
        end
        tick(2);
        check("midrst_busy_before", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_m_valid", {31'b0, m_valid}, 32'h0);
        check("midrst_m_data", m_data, 32'h0);
        check("midrst_m_keep", {28'b0, m_keep}, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(25);
        check("midrst_no_stray_word", gw - gr, 0);
        push(8'h05); push(8'h06); push(8'h07); push(8'h08);
        wait_word("midrst_word", 30, d, k);
        check("midrst_word_data", d, 32'h08070605);
        check("midrst_word_keep", {28'b0, k}, 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_byte_packer.md
Name: fifo_byte_packer

Overview:
- Read-side consumer of the synchronous FIFO. It pops DATA_WIDTH-bit entries and packs PACK_RATIO of them into one wide word, sent out on a valid/ready master stream.
- When the FIFO starves, or on an explicit flush request, it emits a partial word with a lane-keep mask.
- It sits directly downstream of the FIFO: it drives the FIFO's rd_en and consumes its data_out and empty.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry (one lane).
- PACK_RATIO, 4, lanes per output word; legal range 2..16.
- TIMEOUT, 16, consecutive starved cycles before an automatic partial flush; 0 disables the timeout.
- CNT_WIDTH, 5, width of the lane counter and the idle counter. Must hold both PACK_RATIO and TIMEOUT.

Ports:
- clk, in, 1, system clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- fifo_empty, in, 1, FIFO empty flag.
- fifo_data, in, DATA_WIDTH, FIFO data_out. Valid one cycle after fifo_rd_en is sampled high.
- fifo_rd_en, out, 1, FIFO read strobe.
- flush, in, 1, single-cycle request to emit the current partial word.
- m_valid, out, 1, output word valid.
- m_ready, in, 1, downstream accept.
- m_data, out, DATA_WIDTH*PACK_RATIO, packed word. Lane 0 is the first byte popped and occupies the LSBs.
- m_keep, out, PACK_RATIO, lane i valid when bit i = 1.
- busy, out, 1, high whenever the lane count > 0, a read is pending, or m_valid is high.

Behaviour:
- Interface is decided as: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: m_valid=0, m_data=0, m_keep=0, busy=0, fifo_rd_en=0. Internally, lane count=0, pending=0, idle count=0, state=FILL.
- Reset mid-operation discards the partial word and any in-flight byte; no output is generated for them.
- State machine has two states, FILL and OUT.
- FILL:
  - fifo_rd_en = !fifo_empty && (count + pending < PACK_RATIO) && !flush_req. It is combinational and never asserts while fifo_empty=1.
  - pending is set on the edge where fifo_rd_en=1. On the next edge, fifo_data is captured into lane[count], count increments, and pending clears unless a new read was issued.
  - Back-to-back reads are allowed, giving one lane per cycle in steady state.
- FILL to OUT on the edge where any of the following holds:
  - count reaches PACK_RATIO; m_keep = all ones.
  - flush_req is set, count > 0, and pending = 0; m_keep = (1<<count)-1, unused lanes driven 0.
- flush_req:
  - Set by a flush pulse or by the timeout; cleared on entry to OUT.
  - A flush while count=0 and pending=0 is dropped; no empty word is ever emitted.
  - A flush while pending=1 waits for that byte to land and includes it in the word.
- Timeout idle counter:
  - Increments each cycle in FILL with count>0, pending=0 and fifo_empty=1.
  - Clears on any read or state change.
  - When it equals TIMEOUT, flush_req is set on that edge.
- OUT:
  - m_valid=1. m_data and m_keep are held stable until m_ready=1.
  - On the edge with m_valid && m_ready: count, keep and lanes clear, m_valid drops, and the state returns to FILL.
  - No reads are issued in OUT, giving a one-cycle bubble per word.
- A flush pulse arriving in OUT is latched and applied in the next FILL, subject to the same count>0 rule.
- Latency with m_ready=1 and data available: fifo_rd_en for lane 0 rises at cycle 0, and m_valid rises at cycle PACK_RATIO+1.

Decomposition:
- Shared header fifo_pack_defs holds:
  - state encodings: FILL=1'b0, OUT=1'b1;
  - a keep-mask function from count.
- One sub-module, pack_idle_timer: the idle counter plus its compare. Inputs are clk, rst, run, clear; output is expired.

Test Plan:
- Basic pack: FIFO model preloaded 01..08, m_ready=1 -> two words, 0x04030201 then 0x08070605, each with m_keep=0xF. fifo_rd_en asserts exactly 8 times.
- Backpressure: 4 bytes 11,22,33,44 with m_ready=0 for 10 cycles -> m_valid held, m_data=0x44332211 stable, fifo_rd_en=0 throughout. After m_ready=1 -> one transfer, then m_valid=0.
- Timeout flush: 3 bytes AA,BB,CC then FIFO empty -> after exactly 16 starved cycles, m_valid rises with m_data=0x00CCBBAA and m_keep=0x7.
- Explicit flush: flush pulsed while 2 bytes are held and a third read is pending -> word 0x00<b2><b1><b0>, m_keep=0x7. A flush pulse with count=0 -> m_valid stays 0 and busy stays 0.
- Empty guard: fifo_empty toggled randomly for 200 cycles -> fifo_rd_en is never high while fifo_empty=1, and byte order is preserved across all output words.
- Reset mid-word: after 2 bytes, assert rst for 1 cycle -> outputs return to reset values. The next 4 bytes 05..08 -> 0x08070605, m_keep=0xF.
